// File: rtl/fwrisc_loader_pkg.sv
// Shared types and constants for the fwrisc UART program loader.
// The checksum feature is selected by the FWRISC_LOADER_CSUM_EN macro in the top.
package fwrisc_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_OVF  = 3'd5,
    ST_ERR  = 3'd6
  } state_e;

  localparam int unsigned HDR_BYTES  = 4;
  localparam int unsigned WORD_BYTES = 4;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/fwrisc_loader_timeout.sv
// Idle-gap watchdog for the loader: counts clocks without a received byte while enabled
// and raises expire on the clock that would complete TIMEOUT_CYCLES idle clocks.
module fwrisc_loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // A byte on the expiry clock wins: clear masks expire so the caller never aborts then.
  assign expire = (TIMEOUT_CYCLES != 0) && enable && !clear && (cnt == CNT_W'(LIMIT));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!enable || clear || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/fwrisc_program_loader.sv
// UART boot loader: parses a little-endian length-prefixed image into instruction memory,
// then releases the core. Define FWRISC_LOADER_CSUM_EN to require a trailing checksum byte.
module fwrisc_program_loader
  import fwrisc_loader_pkg::*;
#(
  parameter int unsigned MEM_WORDS      = 4096,
  parameter int unsigned ADDR_W         = $clog2(MEM_WORDS),
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_reset_n,
  output logic              program_receiving,
  output logic              program_ov,
  output logic              program_done,
  output logic              program_err,
  output state_e            dbg_state
);

  // Handshake: rx_valid is a one-cycle strobe with no ready; each byte is either consumed
  // on that clock or deliberately dropped (DONE/OVF/ERR). mem_we is a one-cycle write strobe
  // with no acknowledge; mem_addr/mem_wdata are valid only while mem_we is high.

  localparam logic [ADDR_W:0] WIDX_ONE = (ADDR_W+1)'(1);

  state_e            state;
  state_e            state_nxt;
  logic [31:0]       len;
  logic [1:0]        byte_idx;
  logic [ADDR_W:0]   word_idx;
  logic [23:0]       asm_word;
  logic [31:0]       n_full;
  logic              all_written;
  logic              expire;
  logic              to_enable;

  // Length shifts in LSB first; on the last header byte the full count is rx_data on top.
  assign n_full      = {rx_data, len[31:8]};
  assign all_written = (32'(word_idx) == len);
  assign to_enable   = (state == ST_LEN) || ((state == ST_DATA) && !all_written);

  fwrisc_loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock (clock),
    .reset (reset),
    .enable(to_enable),
    .clear (rx_valid),
    .expire(expire)
  );

`ifdef FWRISC_LOADER_CSUM_EN
  localparam state_e EMPTY_NEXT = ST_CSUM;

  logic [7:0] csum;
  logic       csum_ok;

  assign csum_ok     = (rx_data == csum);
  assign program_err = (state == ST_ERR);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      csum <= '0;
    end else if (expire) begin
      csum <= '0;
    end else if (rx_valid && (state == ST_DATA) && !all_written) begin
      csum <= csum_add(csum, rx_data);
    end
  end
`else
  localparam state_e EMPTY_NEXT = ST_DONE;

  assign program_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (rx_valid) state_nxt = ST_LEN;
      end
      ST_LEN: begin
        if (rx_valid && (byte_idx == 2'(HDR_BYTES - 1))) begin
          if (n_full == 32'd0) begin
            state_nxt = EMPTY_NEXT;
          end else if (n_full > 32'(MEM_WORDS)) begin
            state_nxt = ST_OVF;
          end else begin
            state_nxt = ST_DATA;
          end
        end else if (expire) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DATA: begin
        // all_written is first seen during the final mem_we pulse, so the exit lands after it.
        if (all_written) begin
`ifdef FWRISC_LOADER_CSUM_EN
          if (rx_valid) begin
            state_nxt = csum_ok ? ST_DONE : ST_ERR;
          end else begin
            state_nxt = ST_CSUM;
          end
`else
          state_nxt = ST_DONE;
`endif
        end else if (expire) begin
          state_nxt = ST_IDLE;
        end
      end
`ifdef FWRISC_LOADER_CSUM_EN
      ST_CSUM: begin
        if (rx_valid) state_nxt = csum_ok ? ST_DONE : ST_ERR;
      end
`endif
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len       <= '0;
      byte_idx  <= '0;
      word_idx  <= '0;
      asm_word  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (expire) begin
        len      <= '0;
        byte_idx <= '0;
        word_idx <= '0;
        asm_word <= '0;
      end else if (rx_valid) begin
        case (state)
          ST_IDLE, ST_LEN: begin
            len      <= n_full;
            byte_idx <= byte_idx + 2'd1;
          end
          ST_DATA: begin
            if (!all_written) begin
              byte_idx <= byte_idx + 2'd1;
              if (byte_idx == 2'(WORD_BYTES - 1)) begin
                mem_we    <= 1'b1;
                mem_addr  <= word_idx[ADDR_W-1:0];
                mem_wdata <= {rx_data, asm_word};
                word_idx  <= word_idx + WIDX_ONE;
              end else begin
                asm_word <= {rx_data, asm_word[23:8]};
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign program_receiving = (state == ST_LEN) || (state == ST_DATA);
  assign program_ov        = (state == ST_OVF);
  assign program_done      = (state == ST_DONE);
  assign core_reset_n      = (state == ST_DONE);
  assign dbg_state         = state;

endmodule

// File: doc/fwrisc_program_loader.md
Name: fwrisc_program_loader

Overview:
Sequences the UART boot path of the FPGA build: consumes the received byte stream, parses a length-prefixed program image and writes it word-by-word into the fwrisc instruction memory. Holds the core in reset until the image is complete, then releases it. Drives the board status LEDs program_receiving / program_ov / program_done. Sits between the UART receiver and the core/memory inside the FPGA top level.

Parameters:
MEM_WORDS, 4096, instruction memory depth in 32-bit words
ADDR_W, $clog2(MEM_WORDS), word address width (derived)
TIMEOUT_CYCLES, 1000000, max idle clocks between bytes while receiving; 0 disables timeout

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
rx_valid  in  1  one-cycle strobe, rx_data valid
rx_data  in  8  received byte
mem_we  out  1  instruction memory write strobe
mem_addr  out  ADDR_W  word address
mem_wdata  out  32  write data
core_reset_n  out  1  active-low reset to fwrisc core
program_receiving  out  1  image reception in progress
program_ov  out  1  sticky: declared length exceeds MEM_WORDS
program_done  out  1  image loaded, core released
program_err  out  1  sticky: checksum mismatch (0 when feature compiled out)

Behaviour:
- Reset (reset low, async): state IDLE; all outputs 0 (core_reset_n=0, i.e. core held); counters, address, byte index cleared.
- Image format: 4-byte word count N (little-endian), then N words, each 4 bytes little-endian.
- States: IDLE, LEN, DATA, DONE, OVF.
- IDLE: first rx_valid -> byte 0 of N captured, go to LEN.
- LEN: collect bytes 1..3. On 4th byte: N==0 -> DONE; N>MEM_WORDS -> OVF; else DATA, word address=0.
- DATA: assemble bytes LSB first; 4th byte of word -> next cycle mem_we=1 for exactly one cycle, mem_addr=current word index, mem_wdata=assembled word; index increments. Write of word N-1 -> DONE (the cycle after that mem_we pulse).
- DONE: program_done=1, core_reset_n=1. Further rx bytes ignored until reset (single-shot loader).
- OVF: program_ov=1, core stays in reset, all bytes ignored, no memory writes; exits only on reset.
- program_receiving=1 in LEN and DATA only.
- Timeout: in LEN/DATA, idle counter counts clocks since last rx_valid; reaching TIMEOUT_CYCLES -> IDLE, partial word and length discarded, no write issued; counter reset on every rx_valid. TIMEOUT_CYCLES=0: never times out.
- rx_valid on the same cycle as a timeout expiry: byte wins, counter cleared, no abort.
- Throughput: accepts rx_valid every clock; no backpressure (UART rate far below clock).
- mem_addr wraps never: guaranteed by N<=MEM_WORDS check. Counter widths: N 32 bits, word index ADDR_W+1 bits.

Optional Feature:
Macro FWRISC_LOADER_CSUM_EN.
- Defined: after the last data word, one extra byte is expected: 8-bit modulo-256 sum of all data bytes. Extra state CSUM between DATA and DONE. Match -> DONE. Mismatch -> sticky program_err=1, core stays in reset, bytes ignored until reset. N==0 expects checksum byte 0x00.
- Not defined: no CSUM state; DATA goes straight to DONE; program_err tied 0.

Decomposition:
- Package fwrisc_loader_pkg: state enum (IDLE, LEN, DATA, CSUM, DONE, OVF), header byte count constant (4), byte-per-word constant (4).
- One sub-module natural: fwrisc_loader_timeout (idle counter, clear on rx_valid, enable, expiry pulse).

Test Plan:
- Load N=2: bytes 02 00 00 00 | 78 56 34 12 | EF BE AD DE -> mem_we pulses at addr 0 data 0x12345678, addr 1 data 0xDEADBEEF; then program_done=1, core_reset_n=1, program_receiving=0.
- Overflow: N=MEM_WORDS+1 (4097 = 01 10 00 00) -> program_ov=1, zero mem_we pulses during 100 following bytes, core_reset_n=0.
- Timeout: TIMEOUT_CYCLES=50, send 02 00 00 00 11 22, stall 60 clocks -> state IDLE, no write; then full valid image loads to addr 0.
- Back-to-back bytes every clock, N=4 -> 4 writes, addresses 0..3, single-cycle mem_we each; bytes after DONE produce no writes.
- Reset mid-DATA after 1 word written -> all outputs 0 immediately (async), reload from header works.
- With FWRISC_LOADER_CSUM_EN, N=1 data 01 02 03 04: checksum 0x0A -> done; checksum 0x0B -> program_err=1, core_reset_n=0.
